cayde_wb_unit: RTL and testbench

CAYDE_WB_UNIT -- requirements
Module: cayde_wb_unit

---
 rtl/cayde_pkg.sv | 16 +
 rtl/cayde_wb_arb.sv | 52 +++++
 rtl/cayde_wb_unit.sv | 124 ++++++++++++
 tb/tb_cayde_wb_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cayde_pkg.sv
// Shared types for the cayde writeback slice: register address / data widths,
// register count, and the writeback grant encoding.
package cayde_pkg;

  localparam int unsigned NUM_REGS = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] xlen_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_ALU,
    GNT_LSU
  } grant_t;

endpackage

// File: rtl/cayde_wb_arb.sv
// Writeback arbiter: picks ALU or LSU for the single register-file write slot.
// LSU has priority, but after STARVE_MAX consecutive LSU wins against a waiting
// ALU the ALU is granted once. No grant while rst is low.
module cayde_wb_arb
  import cayde_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   alu_valid,
  input  logic   lsu_valid,
  output grant_t grant
);

  logic [2:0] starve_cnt;
  logic [2:0] starve_nxt;

  // Grant selection from the current valids and starvation state
  always_comb begin
    grant = GNT_NONE;
    if (rst) begin
      if (alu_valid && lsu_valid) begin
        grant = (starve_cnt == 3'(STARVE_MAX)) ? GNT_ALU : GNT_LSU;
      end else if (alu_valid) begin
        grant = GNT_ALU;
      end else if (lsu_valid) begin
        grant = GNT_LSU;
      end
    end
  end

  // Count LSU wins while the ALU waits; saturate at STARVE_MAX
  always_comb begin
    starve_nxt = starve_cnt;
    if (!alu_valid || grant == GNT_ALU) begin
      starve_nxt = '0;
    end else if (grant == GNT_LSU && starve_cnt != 3'(STARVE_MAX)) begin
      starve_nxt = starve_cnt + 3'd1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

endmodule

// File: rtl/cayde_wb_unit.sv
// Writeback unit: arbitrates ALU/LSU results into one register-file write
// port (one-cycle registered), and keeps a pending-write scoreboard for hazard
// checks. Optional macro CAYDE_WB_BYPASS_EN adds forwarding outputs and masks
// busy for a register being written this cycle.
module cayde_wb_unit
  import cayde_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid_in,
  input  logic [4:0]  alu_rd_in,
  input  logic [31:0] alu_data_in,
  output logic        alu_ready_out,
  input  logic        lsu_valid_in,
  input  logic [4:0]  lsu_rd_in,
  input  logic [31:0] lsu_data_in,
  output logic        lsu_ready_out,
  input  logic        issue_valid_in,
  input  logic [4:0]  issue_rd_in,
  input  logic [4:0]  chk_rs1_in,
  input  logic [4:0]  chk_rs2_in,
  output logic        busy_rs1_out,
  output logic        busy_rs2_out,
`ifdef CAYDE_WB_BYPASS_EN
  output logic        fwd_rs1_hit_out,
  output logic        fwd_rs2_hit_out,
  output logic [31:0] fwd_data_out,
`endif
  output logic [4:0]  waddr_out,
  output logic [31:0] wdata_out,
  output logic        wen_out,
  output logic [5:0]  pending_cnt_out
);

  grant_t                grant;
  reg_addr_t             sel_rd;
  xlen_t                 sel_data;
  logic [NUM_REGS-1:0]   pend;
  logic [NUM_REGS-1:0]   pend_nxt;
  logic [5:0]            pop_cnt;

  cayde_wb_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid_in),
    .lsu_valid (lsu_valid_in),
    .grant     (grant)
  );

  assign alu_ready_out = (grant == GNT_ALU);
  assign lsu_ready_out = (grant == GNT_LSU);

  // Mux the granted source's result
  always_comb begin
    sel_rd   = alu_rd_in;
    sel_data = alu_data_in;
    if (grant == GNT_LSU) begin
      sel_rd   = lsu_rd_in;
      sel_data = lsu_data_in;
    end
  end

  // Register-file write port; x0 writes are consumed without a write enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wen_out   <= 1'b0;
      waddr_out <= '0;
      wdata_out <= '0;
    end else if (grant != GNT_NONE) begin
      wen_out   <= (sel_rd != 5'd0);
      waddr_out <= sel_rd;
      wdata_out <= sel_data;
    end else begin
      wen_out   <= 1'b0;
    end
  end

  // Scoreboard next state: clear on retiring write, then set on issue (set wins)
  always_comb begin
    pend_nxt = pend;
    if (wen_out) begin
      pend_nxt[waddr_out] = 1'b0;
    end
    if (issue_valid_in) begin
      pend_nxt[issue_rd_in] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  // Population count of the current scoreboard
  always_comb begin
    pop_cnt = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      pop_cnt = pop_cnt + 6'(pend[i]);
    end
  end

  // Scoreboard bits and registered pending count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend            <= '0;
      pending_cnt_out <= '0;
    end else begin
      pend            <= pend_nxt;
      pending_cnt_out <= pop_cnt;
    end
  end

`ifdef CAYDE_WB_BYPASS_EN
  assign fwd_rs1_hit_out = wen_out && (waddr_out == chk_rs1_in);
  assign fwd_rs2_hit_out = wen_out && (waddr_out == chk_rs2_in);
  assign fwd_data_out    = wdata_out;
  assign busy_rs1_out    = pend[chk_rs1_in] && !fwd_rs1_hit_out;
  assign busy_rs2_out    = pend[chk_rs2_in] && !fwd_rs2_hit_out;
`else
  assign busy_rs1_out    = pend[chk_rs1_in];
  assign busy_rs2_out    = pend[chk_rs2_in];
`endif

endmodule

// File: tb/tb_cayde_wb_unit.sv
// Bench for cayde_wb_unit. Honours CAYDE_WB_BYPASS_EN when defined.
module tb_cayde_wb_unit;

  localparam int unsigned SM = 3;

  logic        clk;
  logic        rst;
  logic        alu_valid_in, lsu_valid_in, issue_valid_in;
  logic [4:0]  alu_rd_in, lsu_rd_in, issue_rd_in, chk_rs1_in, chk_rs2_in;
  logic [31:0] alu_data_in, lsu_data_in;
  logic        alu_ready_out, lsu_ready_out, busy_rs1_out, busy_rs2_out;
  logic [4:0]  waddr_out;
  logic [31:0] wdata_out;
  logic        wen_out;
  logic [5:0]  pending_cnt_out;
`ifdef CAYDE_WB_BYPASS_EN
  logic        fwd_rs1_hit_out, fwd_rs2_hit_out;
  logic [31:0] fwd_data_out;
`endif

  int checks = 0;
  int failures = 0;

  cayde_wb_unit #(.STARVE_MAX(SM)) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid_in    (alu_valid_in),
    .alu_rd_in       (alu_rd_in),
    .alu_data_in     (alu_data_in),
    .alu_ready_out   (alu_ready_out),
    .lsu_valid_in    (lsu_valid_in),
    .lsu_rd_in       (lsu_rd_in),
    .lsu_data_in     (lsu_data_in),
    .lsu_ready_out   (lsu_ready_out),
    .issue_valid_in  (issue_valid_in),
    .issue_rd_in     (issue_rd_in),
    .chk_rs1_in      (chk_rs1_in),
    .chk_rs2_in      (chk_rs2_in),
    .busy_rs1_out    (busy_rs1_out),
    .busy_rs2_out    (busy_rs2_out),
`ifdef CAYDE_WB_BYPASS_EN
    .fwd_rs1_hit_out (fwd_rs1_hit_out),
    .fwd_rs2_hit_out (fwd_rs2_hit_out),
    .fwd_data_out    (fwd_data_out),
`endif
    .waddr_out       (waddr_out),
    .wdata_out       (wdata_out),
    .wen_out         (wen_out),
    .pending_cnt_out (pending_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: register file write slot, set of pending registers,
  // and the number of LSU wins the ALU has sat through.
  bit [31:0] m_pend;
  bit        m_wen;
  bit [4:0]  m_waddr;
  bit [31:0] m_wdata;
  int        m_cnt;
  int        m_starve;

  initial begin
    m_pend = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_starve = 0;
  end

  always @(negedge clk) begin
    bit ea, el, eb1, eb2;
    bit [31:0] np;
    if (!rst) begin
      m_pend = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_starve = 0;
    end
    ea = 0; el = 0;
    if (rst) begin
      if (alu_valid_in && lsu_valid_in) begin
        if (m_starve == int'(SM)) ea = 1; else el = 1;
      end else begin
        ea = alu_valid_in;
        el = lsu_valid_in;
      end
    end
    eb1 = m_pend[chk_rs1_in];
    eb2 = m_pend[chk_rs2_in];
`ifdef CAYDE_WB_BYPASS_EN
    if (m_wen && m_waddr == chk_rs1_in) eb1 = 0;
    if (m_wen && m_waddr == chk_rs2_in) eb2 = 0;
    chk("m_fwd1", 32'(fwd_rs1_hit_out), 32'(m_wen && m_waddr == chk_rs1_in));
    chk("m_fwd2", 32'(fwd_rs2_hit_out), 32'(m_wen && m_waddr == chk_rs2_in));
    chk("m_fwd_data", fwd_data_out, m_wdata);
`endif
    chk("m_alu_ready", 32'(alu_ready_out), 32'(ea));
    chk("m_lsu_ready", 32'(lsu_ready_out), 32'(el));
    chk("m_busy1", 32'(busy_rs1_out), 32'(eb1));
    chk("m_busy2", 32'(busy_rs2_out), 32'(eb2));
    chk("m_wen", 32'(wen_out), 32'(m_wen));
    chk("m_waddr", 32'(waddr_out), 32'(m_waddr));
    chk("m_wdata", wdata_out, m_wdata);
    chk("m_pending", 32'(pending_cnt_out), 32'(m_cnt));
    if (rst) begin
      np = m_pend;
      if (m_wen) np[m_waddr] = 0;
      if (issue_valid_in && issue_rd_in != 0) np[issue_rd_in] = 1;
      m_cnt = $countones(m_pend);
      if (ea || !alu_valid_in) m_starve = 0;
      else if (el && m_starve < int'(SM)) m_starve = m_starve + 1;
      if (ea) begin
        m_wen = (alu_rd_in != 0); m_waddr = alu_rd_in; m_wdata = alu_data_in;
      end else if (el) begin
        m_wen = (lsu_rd_in != 0); m_waddr = lsu_rd_in; m_wdata = lsu_data_in;
      end else begin
        m_wen = 0;
      end
      m_pend = np;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    alu_valid_in = 0; lsu_valid_in = 0; issue_valid_in = 0;
  endtask

  initial begin
    rst = 1;
    idle();
    alu_rd_in = 0; lsu_rd_in = 0; issue_rd_in = 0;
    alu_data_in = 0; lsu_data_in = 0; chk_rs1_in = 0; chk_rs2_in = 0;
    #2 rst = 0;
    // reset: readies forced low even with valids up
    alu_valid_in = 1; lsu_valid_in = 1;
    at_neg();
    chk("rst_alu_ready", 32'(alu_ready_out), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_ready_out), 32'd0);
    chk("rst_wen", 32'(wen_out), 32'd0);
    chk("rst_waddr", 32'(waddr_out), 32'd0);
    chk("rst_wdata", wdata_out, 32'd0);
    chk("rst_pending", 32'(pending_cnt_out), 32'd0);
    tick(); tick();
    idle();
    rst = 1;

    // single ALU write to x5
    issue_valid_in = 1; issue_rd_in = 5; chk_rs1_in = 5;
    tick();
    issue_valid_in = 0;
    at_neg();
    chk("x5_busy_set", 32'(busy_rs1_out), 32'd1);
    chk("x5_cnt0", 32'(pending_cnt_out), 32'd0);
    tick();
    alu_valid_in = 1; alu_rd_in = 5; alu_data_in = 32'hDEADBEEF;
    at_neg();
    chk("x5_alu_ready", 32'(alu_ready_out), 32'd1);
    chk("x5_cnt1", 32'(pending_cnt_out), 32'd1);
    tick();
    alu_valid_in = 0;
    at_neg();
    chk("x5_wen", 32'(wen_out), 32'd1);
    chk("x5_waddr", 32'(waddr_out), 32'd5);
    chk("x5_wdata", wdata_out, 32'hDEADBEEF);
`ifndef CAYDE_WB_BYPASS_EN
    chk("x5_busy_during_wb", 32'(busy_rs1_out), 32'd1);
`endif
    tick();
    at_neg();
    chk("x5_wen_pulse", 32'(wen_out), 32'd0);
    chk("x5_busy_clear", 32'(busy_rs1_out), 32'd0);
    chk("x5_cnt_lag", 32'(pending_cnt_out), 32'd1);
    tick();
    at_neg();
    chk("x5_cnt_final", 32'(pending_cnt_out), 32'd0);
    tick();

    // write to x0
    alu_valid_in = 1; alu_rd_in = 0; alu_data_in = 32'h1234; chk_rs2_in = 0;
    at_neg();
    chk("x0_alu_ready", 32'(alu_ready_out), 32'd1);
    chk("x0_busy", 32'(busy_rs2_out), 32'd0);
    tick();
    alu_valid_in = 0;
    at_neg();
    chk("x0_wen", 32'(wen_out), 32'd0);
    chk("x0_wdata", wdata_out, 32'h1234);
    tick();

    // same-cycle clear and re-issue of x7
    issue_valid_in = 1; issue_rd_in = 7;
    tick();
    issue_valid_in = 0; alu_valid_in = 1; alu_rd_in = 7; alu_data_in = 32'h77;
    tick();
    alu_valid_in = 0; issue_valid_in = 1; issue_rd_in = 7; chk_rs1_in = 7;
    at_neg();
    chk("x7_wen", 32'(wen_out), 32'd1);
    chk("x7_waddr", 32'(waddr_out), 32'd7);
    tick();
    issue_valid_in = 0;
    at_neg();
    chk("x7_still_busy", 32'(busy_rs1_out), 32'd1);
    tick();

    // both sources held valid: L,L,L,A repeating
    alu_valid_in = 1; alu_rd_in = 1; alu_data_in = 32'h11;
    lsu_valid_in = 1; lsu_rd_in = 2; lsu_data_in = 32'h22;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      chk("pat_alu", 32'(alu_ready_out), 32'((i % 4) == 3));
      chk("pat_lsu", 32'(lsu_ready_out), 32'((i % 4) != 3));
      tick();
    end
    idle();
    tick();

`ifdef CAYDE_WB_BYPASS_EN
    // forwarding during the x9 write
    issue_valid_in = 1; issue_rd_in = 9;
    tick();
    issue_valid_in = 0; alu_valid_in = 1; alu_rd_in = 9; alu_data_in = 32'hA5A5A5A5;
    tick();
    alu_valid_in = 0; chk_rs1_in = 9;
    at_neg();
    chk("byp_busy", 32'(busy_rs1_out), 32'd0);
    chk("byp_hit", 32'(fwd_rs1_hit_out), 32'd1);
    chk("byp_data", fwd_data_out, 32'hA5A5A5A5);
    tick();
`endif

    // reset while a write is in flight
    issue_valid_in = 1; issue_rd_in = 12; chk_rs1_in = 12;
    tick();
    issue_valid_in = 0; alu_valid_in = 1; alu_rd_in = 12; alu_data_in = 32'hCAFE;
    tick();
    alu_valid_in = 0; rst = 0;
    at_neg();
    chk("mid_rst_wen", 32'(wen_out), 32'd0);
    chk("mid_rst_cnt", 32'(pending_cnt_out), 32'd0);
    chk("mid_rst_busy", 32'(busy_rs1_out), 32'd0);
    tick(); tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("post_rst_wen", 32'(wen_out), 32'd0);
      tick();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 255) != 0);
      alu_valid_in   = 1'($urandom_range(0, 1));
      lsu_valid_in   = ($urandom_range(0, 3) != 0);
      issue_valid_in = 1'($urandom_range(0, 1));
      alu_rd_in      = 5'($urandom_range(0, 15));
      lsu_rd_in      = 5'($urandom_range(0, 15));
      issue_rd_in    = 5'($urandom_range(0, 15));
      chk_rs1_in     = 5'($urandom_range(0, 15));
      chk_rs2_in     = 5'($urandom_range(0, 15));
      alu_data_in    = $urandom;
      lsu_data_in    = $urandom;
      tick();
    end
    rst = 1;
    idle();
    tick();
    at_neg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
